// File: rtl/pc_ctrl_reg.sv
// Program-counter register with selectable next-PC source, OldPC capture,
// misaligned-target trap detection and retired-instruction counter.
module pc_ctrl_reg #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_en,
    input  logic [1:0]       pc_sel,
    input  logic [XLEN-1:0]  target,
    input  logic             old_pc_en,
    input  logic             trap_ack,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  old_pc,
    output logic             misaligned,
    output logic [XLEN-1:0]  bad_addr,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] SEL_INC  = 2'b00;
    localparam logic [1:0] SEL_TGT  = 2'b01;
    localparam logic [1:0] SEL_TRAP = 2'b10;

    // Low-bit mask that must be clear in a target; zero when ALIGN_BITS=0
    localparam logic [XLEN-1:0] AMASK =
        XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    logic tgt_bad;

    assign tgt_bad = |(target & AMASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_VEC;
            old_pc     <= RESET_VEC;
            misaligned <= 1'b0;
            bad_addr   <= '0;
            instret    <= '0;
        end else begin
            if (old_pc_en)
                old_pc <= pc;
            if (trap_ack)
                misaligned <= 1'b0;
            if (pc_en) begin
                case (pc_sel)
                    SEL_INC: begin
                        pc      <= pc + XLEN'(INC);
                        instret <= instret + CNT_W'(1);
                    end
                    SEL_TGT: begin
                        // set overrides a same-edge trap_ack
                        if (tgt_bad) begin
                            pc         <= TRAP_VEC;
                            misaligned <= 1'b1;
                            bad_addr   <= target;
                        end else begin
                            pc      <= target;
                            instret <= instret + CNT_W'(1);
                        end
                    end
                    SEL_TRAP: pc <= TRAP_VEC;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_ctrl_reg.sv
// Randomized and directed bench for pc_ctrl_reg against a behavioural model.
module tb_pc_ctrl_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_en = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] target = '0;
    logic        old_pc_en = 1'b0;
    logic        trap_ack = 1'b0;

    logic [31:0] pc, old_pc, bad_addr, instret;
    logic        misaligned;
    logic [31:0] pc_s, old_pc_s, bad_addr_s;
    logic        misaligned_s;
    logic [3:0]  instret_s;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned m_pc, m_old, m_bad, m_cnt;
    bit          m_mis;

    always #5 clk = ~clk;

    pc_ctrl_reg dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .pc_sel(pc_sel),
        .target(target), .old_pc_en(old_pc_en), .trap_ack(trap_ack),
        .pc(pc), .old_pc(old_pc), .misaligned(misaligned),
        .bad_addr(bad_addr), .instret(instret)
    );

    pc_ctrl_reg #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .pc_en(pc_en), .pc_sel(pc_sel),
        .target(target), .old_pc_en(old_pc_en), .trap_ack(trap_ack),
        .pc(pc_s), .old_pc(old_pc_s), .misaligned(misaligned_s),
        .bad_addr(bad_addr_s), .instret(instret_s)
    );

    // Drive one cycle, advance the model by the stated rules, sample #1 after edge
    task automatic step(input bit r, input bit en, input bit [1:0] sel,
                        input int unsigned tgt, input bit oen, input bit ack);
        int unsigned pre_pc;
        rst = r; pc_en = en; pc_sel = sel;
        target = tgt; old_pc_en = oen; trap_ack = ack;
        @(posedge clk);
        if (r) begin
            m_pc = 0; m_old = 0; m_mis = 0; m_bad = 0; m_cnt = 0;
        end else begin
            pre_pc = m_pc;
            if (oen) m_old = pre_pc;
            if (ack) m_mis = 0;
            if (en) begin
                if (sel == 0) begin
                    m_pc = pre_pc + 4;
                    m_cnt = m_cnt + 1;
                end else if (sel == 1) begin
                    if (tgt % 4 != 0) begin
                        m_pc = 32'h100; m_mis = 1; m_bad = tgt;
                    end else begin
                        m_pc = tgt; m_cnt = m_cnt + 1;
                    end
                end else if (sel == 2) begin
                    m_pc = 32'h100;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, 0, 0);
            n_tests++;
            if (pc !== 0 || old_pc !== 0 || instret !== 0 || misaligned !== 0) begin
                n_fail++;
                $display("FAIL reset%0d: pc=%h old=%h cnt=%0d mis=%b required 0", i,
                         pc, old_pc, instret, misaligned);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (pc !== 0 || old_pc !== 0 || instret !== 0 || misaligned !== 0 ||
            bad_addr !== 0) begin
            n_fail++;
            $display("FAIL reset_release: pc=%h old=%h cnt=%0d mis=%b bad=%h required 0",
                     pc, old_pc, instret, misaligned, bad_addr);
        end
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 0, 0, 0, 0);
            n_tests++;
            if (pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL inc%0d: pc=%h required %h", i, pc, 4 * i);
            end
        end
        n_tests++;
        if (instret !== 3) begin
            n_fail++;
            $display("FAIL inc_cnt: instret=%0d required 3", instret);
        end
        step(0, 0, 0, 32'h40, 0, 0);
        n_tests++;
        if (pc !== 12) begin
            n_fail++;
            $display("FAIL inc_hold: pc=%h required c", pc);
        end
    endtask

    task automatic test_jump();
        step(0, 1, 1, 32'h40, 1, 0);
        n_tests++;
        if (pc !== 32'h40 || old_pc !== 12 || instret !== 4) begin
            n_fail++;
            $display("FAIL jump: pc=%h old=%h cnt=%0d required 40 c 4",
                     pc, old_pc, instret);
        end
    endtask

    task automatic test_misaligned();
        step(0, 1, 1, 32'h42, 0, 0);
        n_tests++;
        if (pc !== 32'h100 || misaligned !== 1 || bad_addr !== 32'h42 ||
            instret !== 4) begin
            n_fail++;
            $display("FAIL misal: pc=%h mis=%b bad=%h cnt=%0d required 100 1 42 4",
                     pc, misaligned, bad_addr, instret);
        end
        step(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (misaligned !== 0 || bad_addr !== 32'h42) begin
            n_fail++;
            $display("FAIL misal_ack: mis=%b bad=%h required 0 42",
                     misaligned, bad_addr);
        end
        step(0, 1, 1, 32'h43, 0, 1);
        n_tests++;
        if (misaligned !== 1 || bad_addr !== 32'h43 || pc !== 32'h100) begin
            n_fail++;
            $display("FAIL misal_ack_set: mis=%b bad=%h pc=%h required 1 43 100",
                     misaligned, bad_addr, pc);
        end
        step(0, 1, 1, 32'h202, 0, 0);
        n_tests++;
        if (dut_s.pc !== 32'h100 || bad_addr_s !== 32'h202) begin
            n_fail++;
            $display("FAIL misal_half: pc=%h bad=%h required 100 202",
                     pc_s, bad_addr_s);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 1, 32'hFFFF_FFFC, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        n_tests++;
        if (pc !== 0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h required 0", pc);
        end
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 0);
        n_tests++;
        if (instret_s !== 4'hF) begin
            n_fail++;
            $display("FAIL cnt_full: instret=%0d required 15", instret_s);
        end
        step(0, 1, 0, 0, 0, 0);
        n_tests++;
        if (instret_s !== 0 || instret !== 16) begin
            n_fail++;
            $display("FAIL cnt_wrap: small=%0d big=%0d required 0 16",
                     instret_s, instret);
        end
    endtask

    task automatic test_hold_trap();
        step(0, 1, 3, 32'h80, 0, 0);
        n_tests++;
        if (pc !== 32'h40 || instret !== 16) begin
            n_fail++;
            $display("FAIL hold: pc=%h cnt=%0d required 40 16", pc, instret);
        end
        step(0, 1, 2, 32'h80, 0, 0);
        n_tests++;
        if (pc !== 32'h100 || instret !== 16) begin
            n_fail++;
            $display("FAIL trap: pc=%h cnt=%0d required 100 16", pc, instret);
        end
        step(1, 1, 1, 32'h80, 1, 0);
        n_tests++;
        if (pc !== 0 || old_pc !== 0 || instret !== 0) begin
            n_fail++;
            $display("FAIL midop_rst: pc=%h old=%h cnt=%0d required 0",
                     pc, old_pc, instret);
        end
    endtask

    task automatic test_random();
        int unsigned t;
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(1, 0) == 1) t = t & 32'hFFFF_FFFC;
            step($urandom_range(49, 0) == 0, $urandom_range(3, 0) != 0,
                 2'($urandom_range(3, 0)), t, $urandom_range(1, 0) == 1,
                 $urandom_range(3, 0) == 0);
            n_tests++;
            if (pc !== m_pc || old_pc !== m_old || misaligned !== m_mis ||
                bad_addr !== m_bad || instret !== m_cnt ||
                instret_s !== 4'(m_cnt % 16)) begin
                n_fail++;
                $display("FAIL rand%0d: pc=%h/%h old=%h/%h mis=%b/%b bad=%h/%h cnt=%0d/%0d small=%0d/%0d (got/required)",
                         i, pc, m_pc, old_pc, m_old, misaligned, m_mis,
                         bad_addr, m_bad, instret, m_cnt, instret_s, m_cnt % 16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_jump();
        test_misaligned();
        test_wrap();
        test_hold_trap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_reg.md
Name: pc_ctrl_reg

Overview:
- Parametrised program-counter register for the multi-cycle RV32 core. Supersedes the bare enable-only PC flop.
- Adds synchronous reset to a reset vector, selectable next-PC source (increment, jump target, trap vector, hold), and OldPC capture for the multi-cycle datapath.
- Adds a target-misalignment check with sticky trap flag and faulting-address capture, plus a retired-instruction counter.
- Sits between the control FSM / ALU result mux and the instruction-memory address port.

Parameters:
XLEN, 32, width of PC, target, old_pc and bad_addr
RESET_VEC, 32'h0000_0000, PC and old_pc value after reset
TRAP_VEC, 32'h0000_0100, PC value loaded on trap select or misaligned redirect
INC, 4, increment applied on sel=INC
ALIGN_BITS, 2, number of target LSBs that must be zero (2 = word-aligned, 1 = halfword)
CNT_W, 32, width of instret counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
pc_en  input  1  PC update strobe from control FSM
pc_sel  input  2  next-PC source: 00 INC, 01 TARGET, 10 TRAP, 11 HOLD
target  input  XLEN  jump/branch target (ALU result)
old_pc_en  input  1  capture current pc into old_pc
trap_ack  input  1  clears sticky misaligned flag
pc  output  XLEN  current PC (registered)
old_pc  output  XLEN  PC of instruction being executed (registered)
misaligned  output  1  sticky misaligned-target flag
bad_addr  output  XLEN  last misaligned target
instret  output  CNT_W  count of completed PC advances

Behaviour:
- Interface: one clock; reset is synchronous and active-high. clk is the clock, rst is the reset. All state changes on posedge clk only; no async paths.
- rst=1 at an edge, regardless of other inputs:
  - pc=RESET_VEC, old_pc=RESET_VEC.
  - misaligned=0, bad_addr=0, instret=0.
  - rst mid-operation discards any pending update.
- All outputs are registered; an update is visible the cycle after the enabling edge (latency 1).
- pc update only when pc_en=1. With pc_en=0, pc holds and pc_sel/target are ignored.
  - sel=00: pc <= pc+INC, modulo 2^XLEN (wraps; e.g. 32'hFFFF_FFFC+4 -> 0).
  - sel=01, target[ALIGN_BITS-1:0]==0: pc <= target.
  - sel=01, misaligned target:
    - pc <= TRAP_VEC.
    - misaligned <= 1, bad_addr <= target.
    - Target is never loaded.
  - sel=10: pc <= TRAP_VEC.
  - sel=11: pc holds, and no counter activity.
- ALIGN_BITS=0 disables the check.
- old_pc_en=1: old_pc <= pc value before this edge's update. Independent of pc_en; simultaneous capture and update is legal and captures the old value.
- instret:
  - Increments by 1 on pc_en=1 with sel=00, or with sel=01 and an aligned target.
  - No increment on trap, hold or misaligned redirect.
  - Wraps from all-ones to 0.
- misaligned is sticky until trap_ack=1. If trap_ack and a new misalignment occur at the same edge, set wins and bad_addr updates.
- bad_addr holds its value after trap_ack; only a new misalignment or rst changes it.

Test Plan:
- Reset: rst=1 for 2 cycles with pc_en=1, sel=00 -> pc=0, old_pc=0, instret=0, misaligned=0 throughout and the cycle after release.
- Increment: 3 edges pc_en=1, sel=00 from reset -> pc=4, 8, 12; instret=3; pc_en=0 edge -> pc stays 12.
- Jump plus OldPC: pc=12, one edge with pc_en=1, sel=01, target=32'h40, old_pc_en=1 -> pc=32'h40, old_pc=12, instret +1.
- Misaligned: sel=01, target=32'h42 -> pc=32'h100, misaligned=1, bad_addr=32'h42, instret unchanged. trap_ack alone -> misaligned=0, bad_addr=32'h42. trap_ack plus target=32'h43 at the same edge -> misaligned=1, bad_addr=32'h43.
- Wrap: load target=32'hFFFF_FFFC, then sel=00 -> pc=0. Force instret to all-ones via a CNT_W=4 instance, one more advance -> instret=0.
- Hold/trap/mid-op reset: sel=11 -> pc unchanged, instret unchanged. sel=10 -> pc=32'h100. rst asserted in the same cycle as sel=01, target=32'h80 -> pc=0.
